// File: rtl/fish_motion_ctrl.sv
// Fish sprite motion controller: spawn, horizontal swim, hook detection, reel-in and catch counting.
// Optional FISH_WOBBLE_EN adds a 2-pixel vertical wobble while swimming.
module fish_motion_ctrl #(
    parameter int SCREEN_W  = 640,
    parameter int FISH_W    = 40,
    parameter int FISH_H    = 33,
    parameter int SWIM_STEP = 2,
    parameter int RISE_STEP = 4,
    parameter int SURFACE_V = 80,
    parameter int HOOK_OFS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       spawn_req_i,
    input  logic       spawn_dir_i,
    input  logic [9:0] spawn_v_i,
    input  logic       hook_active_i,
    input  logic [9:0] hook_h_i,
    input  logic [9:0] hook_v_i,
    output logic [9:0] fish_h_position_o,
    output logic [9:0] fish_v_position_o,
    output logic [1:0] fish_way_o,
    output logic       fish_appear_o,
    output logic       caught_o,
    output logic       escaped_o,
    output logic [7:0] catch_count_o
);

    typedef enum logic [2:0] {S_IDLE, S_SWIM_L, S_SWIM_R, S_HOOKED, S_CAUGHT} state_t;

    localparam logic [9:0] RIGHT_EDGE = 10'(SCREEN_W + FISH_W);
    localparam logic [9:0] REEL_LIMIT = 10'(SURFACE_V + RISE_STEP);

    state_t      state_q, state_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [1:0]  way_q, way_d;
    logic        esc_q, esc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [9:0]  v_drv;
    logic [10:0] hook_sum;
    logic [9:0]  hook_track;
    logic        col_hit, row_hit, hit;
    logic        swimming;

    assign swimming = (state_q == S_SWIM_L) || (state_q == S_SWIM_R);

`ifdef FISH_WOBBLE_EN
    logic [3:0] wob_q, wob_d;
    assign v_drv = v_q + ((swimming && wob_q[3]) ? 10'd2 : 10'd0);
`else
    assign v_drv = v_q;
`endif

    assign hook_sum   = {1'b0, hook_h_i} + 11'(HOOK_OFS);
    assign hook_track = hook_sum[10] ? 10'h3FF : hook_sum[9:0];

    // Widened compares so a fish near column 0 needs no wrap-around.
    assign col_hit = ({1'b0, hook_h_i} + 11'(FISH_W) >= {1'b0, h_q}) && (hook_h_i < h_q);
    assign row_hit = (hook_v_i >= v_drv) && ({1'b0, hook_v_i} <= {1'b0, v_drv} + 11'(FISH_H - 1));
    assign hit     = hook_active_i && col_hit && row_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            way_q   <= '0;
            esc_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef FISH_WOBBLE_EN
            wob_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            way_q   <= way_d;
            esc_q   <= esc_d;
            cnt_q   <= cnt_d;
`ifdef FISH_WOBBLE_EN
            wob_q   <= wob_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        way_d   = way_q;
        esc_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef FISH_WOBBLE_EN
        wob_d   = wob_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (spawn_req_i) begin
                    v_d = spawn_v_i;
`ifdef FISH_WOBBLE_EN
                    wob_d = '0;
`endif
                    if (spawn_dir_i) begin
                        h_d = '0;          way_d = 2'd1; state_d = S_SWIM_R;
                    end else begin
                        h_d = RIGHT_EDGE;  way_d = 2'd0; state_d = S_SWIM_L;
                    end
                end
            end
            S_SWIM_L, S_SWIM_R: begin
                if (tick_i) begin
`ifdef FISH_WOBBLE_EN
                    wob_d = wob_q + 4'd1;
`endif
                    if (hit) begin
                        state_d = S_HOOKED;
                        way_d   = 2'd2;
                        h_d     = hook_track;
                        v_d     = hook_v_i;
                    end else if ((state_q == S_SWIM_L && h_q < 10'(SWIM_STEP)) ||
                                 (state_q == S_SWIM_R && h_q >= RIGHT_EDGE)) begin
                        esc_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (state_q == S_SWIM_L) begin
                        h_d = h_q - 10'(SWIM_STEP);
                    end else begin
                        h_d = h_q + 10'(SWIM_STEP);
                    end
                end
            end
            S_HOOKED: begin
                if (!hook_active_i) begin
                    esc_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (tick_i) begin
                    h_d = hook_track;
                    if (v_q <= REEL_LIMIT) begin
                        v_d     = 10'(SURFACE_V);
                        state_d = S_CAUGHT;
                    end else begin
                        v_d = v_q - 10'(RISE_STEP);
                    end
                end
            end
            S_CAUGHT: begin
                state_d = S_IDLE;
                if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fish_h_position_o = h_q;
        fish_v_position_o = v_drv;
        fish_way_o        = way_q;
        fish_appear_o     = (state_q != S_IDLE);
        caught_o          = (state_q == S_CAUGHT);
        escaped_o         = esc_q;
        catch_count_o     = cnt_q;
    end

endmodule

// File: tb/tb_fish_motion_ctrl.sv
// Directed bench for fish_motion_ctrl: spawn, swim, escape, hit, reel-in, saturation, reset and wobble.
module tb_fish_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, spawn_req = 1'b0, spawn_dir = 1'b0, hook_active = 1'b0;
    logic [9:0] spawn_v = '0, hook_h = '0, hook_v = '0;
    logic [9:0] h_pos, v_pos;
    logic [1:0] way;
    logic       appear, caught, escaped;
    logic [7:0] count;
    int checks = 0;
    int errors = 0;

`ifdef FISH_WOBBLE_EN
    localparam logic [9:0] WOB_HI = 10'd302;
`else
    localparam logic [9:0] WOB_HI = 10'd300;
`endif

    fish_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick_i(tick), .spawn_req_i(spawn_req),
        .spawn_dir_i(spawn_dir), .spawn_v_i(spawn_v), .hook_active_i(hook_active),
        .hook_h_i(hook_h), .hook_v_i(hook_v), .fish_h_position_o(h_pos),
        .fish_v_position_o(v_pos), .fish_way_o(way), .fish_appear_o(appear),
        .caught_o(caught), .escaped_o(escaped), .catch_count_o(count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if ({h_pos, v_pos, way, appear, caught, escaped, count} !== 33'd0) begin
            errors++; $display("FAIL reset_outputs got %h required 0", {h_pos, v_pos, way, appear, caught, escaped, count});
        end
        rst_n = 1'b1;
        step();
        checks++; if (appear !== 1'b0) begin errors++; $display("FAIL idle_appear got %0d required 0", appear); end
    endtask

    task automatic test_spawn_left();
        spawn_req = 1'b1; spawn_dir = 1'b0; spawn_v = 10'd300; tick = 1'b0;
        step();
        spawn_req = 1'b0;
        checks++; if (h_pos !== 10'd680) begin errors++; $display("FAIL spawn_h got %0d required 680", h_pos); end
        checks++; if (v_pos !== 10'd300) begin errors++; $display("FAIL spawn_v got %0d required 300", v_pos); end
        checks++; if (way !== 2'd0 || appear !== 1'b1) begin errors++; $display("FAIL spawn_way_appear got %0d/%0d required 0/1", way, appear); end
        step();
        checks++; if (h_pos !== 10'd680) begin errors++; $display("FAIL no_tick_hold got %0d required 680", h_pos); end
        tick = 1'b1;
        step();
        checks++; if (h_pos !== 10'd678) begin errors++; $display("FAIL swim_left_step got %0d required 678", h_pos); end
    endtask

    task automatic test_left_escape();
        repeat (339) step();
        checks++; if (h_pos !== 10'd0 || escaped !== 1'b0) begin errors++; $display("FAIL left_at_zero got %0d esc %0d required 0 esc 0", h_pos, escaped); end
        step();
        tick = 1'b0;
        checks++; if (escaped !== 1'b1 || appear !== 1'b0) begin errors++; $display("FAIL left_escape got esc %0d appear %0d required 1/0", escaped, appear); end
        step();
        checks++; if (escaped !== 1'b0) begin errors++; $display("FAIL escape_width got %0d required 0", escaped); end
        checks++; if (count !== 8'd0 || caught !== 1'b0) begin errors++; $display("FAIL escape_count got %0d required 0", count); end
    endtask

    task automatic test_right_hit();
        spawn_req = 1'b1; spawn_dir = 1'b1; spawn_v = 10'd200;
        step();
        spawn_req = 1'b0; tick = 1'b1;
        repeat (50) step();
        checks++; if (h_pos !== 10'd100 || way !== 2'd1) begin errors++; $display("FAIL right_advance got %0d way %0d required 100 way 1", h_pos, way); end
        hook_active = 1'b1; hook_h = 10'd100; hook_v = 10'd210;
        step();
        checks++; if (h_pos !== 10'd102 || way !== 2'd1) begin errors++; $display("FAIL hit_upper_bound got %0d way %0d required 102 way 1", h_pos, way); end
        hook_h = 10'd80;
        step();
        checks++; if (way !== 2'd2 || h_pos !== 10'd96 || v_pos !== 10'd210) begin
            errors++; $display("FAIL right_hit got way %0d h %0d v %0d required 2/96/210", way, h_pos, v_pos);
        end
    endtask

    task automatic test_reel_in();
        repeat (32) step();
        checks++; if (v_pos !== 10'd82 || h_pos !== 10'd96 || caught !== 1'b0) begin
            errors++; $display("FAIL reel_rise got v %0d h %0d caught %0d required 82/96/0", v_pos, h_pos, caught);
        end
        step();
        checks++; if (caught !== 1'b1 || v_pos !== 10'd80 || escaped !== 1'b0) begin
            errors++; $display("FAIL reel_caught got caught %0d v %0d esc %0d required 1/80/0", caught, v_pos, escaped);
        end
        tick = 1'b0;
        step();
        checks++; if (caught !== 1'b0 || count !== 8'd1 || appear !== 1'b0) begin
            errors++; $display("FAIL reel_done got caught %0d count %0d appear %0d required 0/1/0", caught, count, appear);
        end
    endtask

    task automatic test_hook_drop();
        hook_active = 1'b0; spawn_req = 1'b1; spawn_dir = 1'b1; spawn_v = 10'd200;
        step();
        spawn_req = 1'b0; tick = 1'b1;
        repeat (50) step();
        hook_active = 1'b1; hook_h = 10'd80; hook_v = 10'd210;
        repeat (4) step();
        checks++; if (way !== 2'd2 || v_pos !== 10'd198) begin errors++; $display("FAIL drop_rise got way %0d v %0d required 2/198", way, v_pos); end
        tick = 1'b0; hook_active = 1'b0;
        step();
        checks++; if (escaped !== 1'b1 || appear !== 1'b0 || caught !== 1'b0) begin
            errors++; $display("FAIL hook_drop got esc %0d appear %0d caught %0d required 1/0/0", escaped, appear, caught);
        end
        step();
        checks++; if (escaped !== 1'b0 || count !== 8'd1) begin errors++; $display("FAIL drop_after got esc %0d count %0d required 0/1", escaped, count); end
    endtask

    task automatic test_saturation();
        hook_active = 1'b1; hook_h = 10'd0; hook_v = 10'd80;
        spawn_req = 1'b1; spawn_dir = 1'b1; spawn_v = 10'd80; tick = 1'b1;
        for (int i = 0; i < 254; i++) begin
            repeat (5) step();
            if (i == 0) begin
                checks++; if (count !== 8'd2) begin errors++; $display("FAIL quick_catch got %0d required 2", count); end
            end
        end
        checks++; if (count !== 8'd255) begin errors++; $display("FAIL count_255 got %0d required 255", count); end
        repeat (5) step();
        checks++; if (count !== 8'd255) begin errors++; $display("FAIL count_saturate got %0d required 255", count); end
        spawn_req = 1'b0; tick = 1'b0; hook_active = 1'b0;
    endtask

    task automatic test_async_reset();
        spawn_req = 1'b1; spawn_dir = 1'b1; spawn_v = 10'd300;
        step();
        spawn_req = 1'b0; tick = 1'b1;
        repeat (5) step();
        checks++; if (h_pos !== 10'd10 || appear !== 1'b1) begin errors++; $display("FAIL pre_reset got h %0d appear %0d required 10/1", h_pos, appear); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({h_pos, v_pos, way, appear, caught, escaped, count} !== 33'd0) begin
            errors++; $display("FAIL async_reset got %h required 0", {h_pos, v_pos, way, appear, caught, escaped, count});
        end
        step();
        checks++; if (escaped !== 1'b0 || caught !== 1'b0) begin errors++; $display("FAIL reset_pulse got esc %0d caught %0d required 0/0", escaped, caught); end
        #2 rst_n = 1'b1;
        tick = 1'b0;
        step();
    endtask

    task automatic test_wobble();
        spawn_req = 1'b1; spawn_dir = 1'b1; spawn_v = 10'd300;
        step();
        spawn_req = 1'b0; tick = 1'b1;
        checks++; if (v_pos !== 10'd300) begin errors++; $display("FAIL wobble_t0 got %0d required 300", v_pos); end
        repeat (7) step();
        checks++; if (v_pos !== 10'd300) begin errors++; $display("FAIL wobble_t7 got %0d required 300", v_pos); end
        step();
        checks++; if (v_pos !== WOB_HI) begin errors++; $display("FAIL wobble_t8 got %0d required %0d", v_pos, WOB_HI); end
        repeat (7) step();
        checks++; if (v_pos !== WOB_HI) begin errors++; $display("FAIL wobble_t15 got %0d required %0d", v_pos, WOB_HI); end
        step();
        checks++; if (v_pos !== 10'd300) begin errors++; $display("FAIL wobble_t16 got %0d required 300", v_pos); end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spawn_left();
        test_left_escape();
        test_right_hit();
        test_reel_in();
        test_hook_drop();
        test_saturation();
        test_async_reset();
        test_wobble();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
